// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format select encoding,
// buffer occupancy states and the XLEN legality check.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_J     = 3'd3,
    IMM_U     = 3'd4,
    IMM_ZIMM  = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_ILL   = 3'd7
  } imm_sel_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for all RISC-V formats, extended
// to XLEN bits. Format 7 is illegal and yields zero with err set.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_sel_t        sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (sel)
      IMM_I:    imm = XLEN'($signed(instr[31:20]));
      IMM_S:    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:    imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:    imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:    imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_ZIMM: imm = XLEN'(instr[19:15]);
      IMM_SHAMT: begin
        // RV64 shift amounts carry one extra bit.
        if (XLEN == 64) imm = XLEN'(instr[25:20]);
        else            imm = XLEN'(instr[24:20]);
      end
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes at enqueue into a two-entry
// elastic buffer with valid/ready on both sides, sideband tag and flush.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [TAGW-1:0] tag;
    logic            err;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  entry_t          mem [2];
  logic            wr_ptr, rd_ptr;
  occ_state_t      state, state_nxt;
  logic            enq, deq;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (instr),
    .sel   (imm_sel_t'(sel)),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      OCC_EMPTY: if (enq) state_nxt = OCC_ONE;
      OCC_ONE: begin
        if (enq && !deq)      state_nxt = OCC_FULL;
        else if (deq && !enq) state_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (deq) state_nxt = OCC_ONE;
      default:   state_nxt = OCC_EMPTY;
    endcase
    if (flush) state_nxt = OCC_EMPTY;
  end

  // in_ready is derived from the next occupancy, so it never depends
  // combinationally on out_ready.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= OCC_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != OCC_FULL);
    end
  end

  // NOTE: the two storage slots are reset so out_imm/out_tag are never X
  // after reset; they are tiny, so the reset costs little.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= '{imm: dec_imm, tag: in_tag, err: dec_err};
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
    end
  end

  assign out_valid = (state != OCC_EMPTY);
  assign out_imm   = mem[rd_ptr].imm;
  assign out_tag   = mem[rd_ptr].tag;
  assign out_err   = mem[rd_ptr].err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and
// are checked every cycle against a queue model plus literal expectations.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  sel = '0;
  logic [31:0] in_tag = '0;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAGW(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .instr(instr), .sel(sel), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAGW(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .instr(instr), .sel(sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference immediate built from bit weights and two's-complement arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int s, input bit x64);
    longint v;
    v = 0;
    case (s)
      0: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; end
      1: begin v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); if (v >= 2048) v -= 4096; end
      2: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3: begin
        v = longint'(ins[31]) * (longint'(1) << 20) + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
      end
      4: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v -= (longint'(1) << 32); end
      5: v = longint'(ins[19:15]);
      6: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    return x64 ? 64'(v) : {32'b0, v[31:0]};
  endfunction

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [31:0] tag;
    logic        err;
  } ent_t;

  ent_t q[$];

  always @(posedge clk or negedge reset_n) begin : model
    bit   do_enq, do_deq;
    ent_t e;
    if (!reset_n) q.delete();
    else if (flush) q.delete();
    else begin
      do_enq = in_valid && (q.size() < 2);
      do_deq = out_ready && (q.size() > 0);
      if (do_enq) begin
        e.imm32 = ref_imm(instr, int'(sel), 1'b0)[31:0];
        e.imm64 = ref_imm(instr, int'(sel), 1'b1);
        e.tag   = in_tag;
        e.err   = (sel == 3'd7);
      end
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back(e);
    end
  end

  always @(negedge clk) begin : compare
    if (reset_n) begin
      check("valid32", 64'(out_valid32), 64'(q.size() > 0));
      check("valid64", 64'(out_valid64), 64'(q.size() > 0));
      check("ready32", 64'(in_ready32), 64'(q.size() < 2));
      check("ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        check("imm32", 64'(out_imm32), 64'(q[0].imm32));
        check("imm64", out_imm64, q[0].imm64);
        check("tag32", 64'(out_tag32), 64'(q[0].tag));
        check("tag64", 64'(out_tag64), 64'(q[0].tag));
        check("err32", 64'(out_err32), 64'(q[0].err));
        check("err64", 64'(out_err64), 64'(q[0].err));
      end
    end
  end

  // Directed single entry: called at a negedge with out_ready high.
  task automatic send(input logic [31:0] ins, input logic [2:0] s, input logic [31:0] tg,
                      input logic [63:0] e32, input logic [63:0] e64, input logic e_err);
    in_valid  = 1'b1;
    instr     = ins;
    sel       = s;
    in_tag    = tg;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("lit_valid", 64'(out_valid32), 64'd1);
    check("lit_imm32", 64'(out_imm32), e32);
    check("lit_imm64", out_imm64, e64);
    check("lit_tag", 64'(out_tag32), 64'(tg));
    check("lit_err", 64'(out_err64), 64'(e_err));
  endtask

  task automatic offer(input logic [31:0] tg);
    in_valid = 1'b1;
    instr    = 32'h0000_0013;
    sel      = 3'd0;
    in_tag   = tg;
  endtask

  initial begin
    // Pin the reference model itself.
    check("pin_b", ref_imm(32'hFE000EE3, 2, 1'b0), 64'hFFFF_FFFC);
    check("pin_s", ref_imm(32'hFE112E23, 1, 1'b1), 64'hFFFF_FFFF_FFFF_FFFC);
    check("pin_j", ref_imm(32'hFFDFF06F, 3, 1'b0), 64'hFFFF_FFFC);

    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid32), 64'd0);
    check("rst_imm", out_imm64, 64'd0);
    check("rst_tag", 64'(out_tag32), 64'd0);
    check("rst_err", 64'(out_err32), 64'd0);
    check("rst_ready", 64'(in_ready64), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    send(32'hFFF00093, 3'd0, 32'h1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(32'h12345037, 3'd4, 32'h2, 64'h1234_5000, 64'h1234_5000, 1'b0);
    send(32'hFFDFF06F, 3'd3, 32'h3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'h000F8000, 3'd5, 32'h4, 64'h1F, 64'h1F, 1'b0);
    send(32'hDEADBEEF, 3'd7, 32'h5, 64'h0, 64'h0, 1'b1);
    send(32'h800000B7, 3'd4, 32'h6, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(32'h03F0D093, 3'd6, 32'h7, 64'h1F, 64'h3F, 1'b0);
    send(32'hFE000EE3, 3'd2, 32'h8, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send(32'hFE112E23, 3'd1, 32'h9, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    @(negedge clk);

    // Backpressure: A and B fill the buffer, C waits.
    out_ready = 1'b0;
    offer(32'hA);
    @(negedge clk);
    offer(32'hB);
    @(negedge clk);
    offer(32'hC);
    check("bp_ready_low", 64'(in_ready32), 64'd0);
    @(negedge clk);
    check("bp_hold_ready", 64'(in_ready64), 64'd0);
    check("bp_head_a", 64'(out_tag32), 64'hA);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_head_b", 64'(out_tag32), 64'hB);
    @(negedge clk);
    check("bp_head_c", 64'(out_tag64), 64'hC);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", 64'(out_valid32), 64'd0);

    // Flush while FULL with a same-edge input.
    out_ready = 1'b0;
    offer(32'h11);
    @(negedge clk);
    offer(32'h12);
    @(negedge clk);
    offer(32'hD);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 64'(out_valid32), 64'd0);
    check("fl_ready", 64'(in_ready32), 64'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("fl_gone", 64'(out_valid64), 64'd0);

    // Asynchronous reset while one entry is held.
    out_ready = 1'b0;
    offer(32'h55);
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_before", 64'(out_valid32), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid32", 64'(out_valid32), 64'd0);
    check("ar_valid64", 64'(out_valid64), 64'd0);
    check("ar_ready", 64'(in_ready32), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(32'h00500093, 3'd0, 32'h66, 64'h5, 64'h5, 1'b0);
    @(negedge clk);

    // Randomised traffic checked cycle by cycle against the queue model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      instr     = $urandom;
      sel       = 3'($urandom_range(0, 7));
      in_tag    = $urandom;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the pipelined core's decode stage. It extracts and extends the immediate of a 32-bit instruction into an XLEN-wide operand for I, S, B, J, U, CSR-zimm and shift-amount formats. Results pass through a two-entry elastic buffer with valid/ready handshakes on both sides, so decode and execute can stall independently. A sideband tag is carried alongside each result, and a flush input is provided for branch mispredict and trap redirect.

## Interface
- `XLEN`, default 32: output width; legal values are 32 and 64.
- `TAGW`, default 32: sideband tag width (PC or ROB id); passed through untouched.
- `clk` in, 1: single clock, rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `flush` in, 1: synchronous; discards all buffered entries.
- `in_valid` in, 1: `instr`, `sel` and `in_tag` are valid.
- `in_ready` out, 1: buffer can accept an entry this cycle.
- `instr` in, 32: raw instruction word.
- `sel` in, 3: format select, encoded as `imm_sel_t`.
- `in_tag` in, `TAGW`: sideband tag.
- `out_valid` out, 1: the head entry is valid.
- `out_ready` in, 1: consumer accepts the head entry.
- `out_imm` out, `XLEN`: extended immediate.
- `out_tag` out, `TAGW`: tag of the head entry.
- `out_err` out, 1: the head entry used an illegal `sel`.

## Operation
- Format decode, where `s` is `instr[31]` replicated to `XLEN`:
  - 0 I: `s`, `instr[30:20]`
  - 1 S: `s`, `instr[30:25]`, `instr[11:7]`
  - 2 B: `s`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, `0`
  - 3 J: `s`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, `0`
  - 4 U: `instr[31:12]`, `12'b0`, sign-extended from bit 31 when `XLEN=64`
  - 5 ZIMM: zero-extended `instr[19:15]`
  - 6 SHAMT: zero-extended `instr[24:20]` when `XLEN=32`; `instr[25:20]` when `XLEN=64`
  - 7: illegal; `out_imm = 0`, `out_err = 1`
- B and J immediates include bit 0 = 0 and are byte offsets.
- Buffer: 2-entry FIFO holding {`imm`, `tag`, `err`}. Decode happens at enqueue; stored values are final.
- Enqueue fires when `in_valid && in_ready`. Dequeue fires when `out_valid && out_ready`.
- `in_ready` is registered: it is 1 when the occupancy after the current cycle is below 2. No combinational path runs from `out_ready` to `in_ready`.
- Occupancy states: EMPTY, ONE, FULL.
  - EMPTY: enqueue goes to ONE.
  - ONE: enqueue only goes to FULL; dequeue only goes to EMPTY; both together stay in ONE with the new entry at the head.
  - FULL: dequeue goes to ONE. Enqueue is impossible because `in_ready` is 0.
- `flush` has priority over enqueue and dequeue. The next state is EMPTY and any same-cycle input is dropped.
- Entries leave in strict FIFO order.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on `out_*` after edge N, with `out_valid` = 1 in cycle N+1.
- Throughput is 1 entry/cycle while `out_ready` is held at 1.
- `out_*` stay stable while `out_valid && !out_ready`.
- Reset values (async assert, synchronous-safe deassert):
  - `out_valid` = 0, `out_imm` = 0, `out_tag` = 0, `out_err` = 0
  - `in_ready` = 1, state EMPTY
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- After `flush` at edge N: `out_valid` = 0 and `in_ready` = 1 in cycle N+1.
- `out_imm` and `out_tag` are don't-care while `out_valid` = 0, but they must not be X after reset.

## Structure
- Package `imm_pkg` holds:
  - `imm_sel_t` enum with values `IMM_I`, `IMM_S`, `IMM_B`, `IMM_J`, `IMM_U`, `IMM_ZIMM`, `IMM_SHAMT`, `IMM_ILL`
  - an `XLEN` legality check
- Sub-module `imm_decode`: purely combinational, parametrised by `XLEN`. Takes `instr` and `sel`; produces `imm` and `err`.
- Top level holds the 2-entry storage, read/write pointers, occupancy state and the registered `in_ready`.

## Test plan
- I and U formats, `XLEN=32`:
  - `instr=0xFFF00093`, `sel=0` → `out_imm=0xFFFFFFFF` one cycle later.
  - `instr=0x12345037`, `sel=4` → `0x12345000`.
- J format: `instr=0xFFDFF06F`, `sel=3` → `0xFFFFFFFC`. ZIMM: `instr` with `[19:15]=5'h1F`, `sel=5` → `0x0000001F`. `sel=7` → `out_imm=0`, `out_err=1`.
- `XLEN=64`:
  - `instr=0x800000B7`, `sel=4` → `0xFFFFFFFF80000000`.
  - `instr=0x03F0D093`, `sel=6` → `0x3F`.
- Backpressure:
  - Hold `out_ready=0` and offer tags A, B, C back-to-back → A and B accepted; `in_ready` = 0 from the cycle after B; C held.
  - Then raise `out_ready` → outputs A, B, C in order with no loss or duplication.
- Flush with FULL and `in_valid=1` on the same edge → next cycle `out_valid=0` and `in_ready=1`; the input offered with the flush never appears.
- Reset mid-stream: drop `reset_n` between edges while ONE → `out_valid` goes to 0 immediately; after release, a fresh entry appears with latency 1.
